// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style PIC host bus master.
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      ACK1,
      GAP,
      ACK2,
      RECOV
   } pic_state_e;

   localparam int INTA_PULSES       = 2;
   localparam int DEF_STROBE_CYCLES = 2;
   localparam int DEF_GAP_CYCLES    = 2;

   // Counter load value on entry to a state: the state lasts load+1 cycles.
   function automatic logic [3:0] state_len(input pic_state_e s,
                                            input int strobe_cycles,
                                            input int gap_cycles);
      logic [3:0] len;
      case (s)
         STROBE, ACK1, ACK2: len = 4'(strobe_cycles - 1);
         GAP, RECOV:         len = 4'(gap_cycles - 1);
         default:            len = 4'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/pic_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module pic_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pic_host_master.sv
// Host-side bus master for an 8259-style PIC: register read/write cycles and
// the two-pulse INTA acknowledge with vector capture.
module pic_host_master
   import pic_pkg::*;
#(
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_read,
   input  logic       cmd_a0,
   input  logic [7:0] cmd_data,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic [7:0] vec_data,
   output logic       vec_valid,
   output logic       busy,
   output logic       CS_n,
   output logic       WR_n,
   output logic       RD_n,
   output logic       A0,
   output logic [7:0] D_out,
   output logic       D_oe,
   input  logic [7:0] D_in,
   input  logic       INT,
   output logic       INTA
);

   pic_state_e state, state_d;
   logic [3:0] cnt;
   logic       int_s;
   logic       lat_read;
   logic       accept;
   logic       read_d;
   logic       bus_d;
   logic       cap_rd;
   logic       cap_vec;

   pic_sync2 u_int_sync (
      .clk   (clk),
      .reset (reset),
      .d     (INT),
      .q     (int_s)
   );

   // A pending interrupt hides cmd_ready, so acknowledge wins a same-cycle race.
   assign cmd_ready = (state == IDLE) && !int_s && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);
   assign read_d    = accept ? cmd_read : lat_read;
   assign bus_d     = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
   assign cap_rd    = (state == STROBE) && (cnt == 4'd0) && lat_read;
   assign cap_vec   = (state == ACK2) && (cnt == 4'd0);

   // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (int_s)       state_d = ACK1;
            else if (accept) state_d = SETUP;
         end
         SETUP:  state_d = STROBE;
         STROBE: if (cnt == 4'd0) state_d = HOLD;
         HOLD:   state_d = RECOV;
         ACK1:   if (cnt == 4'd0) state_d = GAP;
         GAP:    if (cnt == 4'd0) state_d = ACK2;
         ACK2:   if (cnt == 4'd0) state_d = RECOV;
         RECOV:  if (cnt == 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus pins are decoded from the next state and registered, so each pin
   // changes together with the state it belongs to and never glitches.
   // NOTE: every register here uses <= so all of them sample the pre-edge
   // values of state, cnt and lat_read, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the data registers are reset too because their post-reset
         // value is visible on rd_data, vec_data and D_out.
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_read  <= 1'b0;
         A0        <= 1'b0;
         D_out     <= 8'h00;
         CS_n      <= 1'b1;
         WR_n      <= 1'b1;
         RD_n      <= 1'b1;
         D_oe      <= 1'b0;
         INTA      <= 1'b1;
         rd_data   <= 8'h00;
         rd_valid  <= 1'b0;
         vec_data  <= 8'h00;
         vec_valid <= 1'b0;
      end else begin
         state <= state_d;
         if (state_d != state)
            cnt <= state_len(state_d, STROBE_CYCLES, GAP_CYCLES);
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;

         if (accept) begin
            lat_read <= cmd_read;
            A0       <= cmd_a0;
            D_out    <= cmd_data;
         end

         CS_n <= !bus_d;
         WR_n <= !((state_d == STROBE) && !read_d);
         RD_n <= !((state_d == STROBE) && read_d);
         D_oe <= bus_d && !read_d;
         INTA <= !((state_d == ACK1) || (state_d == ACK2));

         rd_valid  <= cap_rd;
         vec_valid <= cap_vec;
         if (cap_rd)  rd_data  <= D_in;
         if (cap_vec) vec_data <= D_in;
      end
   end

endmodule

// File: tb/tb_pic_host_master.sv
// Directed bench for pic_host_master: default-timed instance plus a
// STROBE_CYCLES=1 / GAP_CYCLES=15 instance, both driven by a small PIC model.
module tb_pic_host_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] pic_reg, pic_vec;

   logic       cmd_valid1, cmd_read1, cmd_a01, int1;
   logic [7:0] cmd_data1;
   logic       cmd_ready1, rd_valid1, vec_valid1, busy1;
   logic       cs_n1, wr_n1, rd_n1, a01, d_oe1, inta1;
   logic [7:0] rd_data1, vec_data1, d_out1, d_in1;

   logic       cmd_valid2, cmd_read2, cmd_a02, int2;
   logic [7:0] cmd_data2;
   logic       cmd_ready2, rd_valid2, vec_valid2, busy2;
   logic       cs_n2, wr_n2, rd_n2, a02, d_oe2, inta2;
   logic [7:0] rd_data2, vec_data2, d_out2, d_in2;

   // PIC model: register byte while RD_n is low, vector byte while INTA is low.
   assign d_in1 = !rd_n1 ? pic_reg : (!inta1 ? pic_vec : 8'h00);
   assign d_in2 = !rd_n2 ? pic_reg : (!inta2 ? pic_vec : 8'h00);

   pic_host_master dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_read(cmd_read1), .cmd_a0(cmd_a01), .cmd_data(cmd_data1),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .vec_data(vec_data1),
      .vec_valid(vec_valid1), .busy(busy1), .CS_n(cs_n1), .WR_n(wr_n1),
      .RD_n(rd_n1), .A0(a01), .D_out(d_out1), .D_oe(d_oe1), .D_in(d_in1),
      .INT(int1), .INTA(inta1)
   );

   pic_host_master #(.STROBE_CYCLES(1), .GAP_CYCLES(15)) dut2 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_read(cmd_read2), .cmd_a0(cmd_a02), .cmd_data(cmd_data2),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .vec_data(vec_data2),
      .vec_valid(vec_valid2), .busy(busy2), .CS_n(cs_n2), .WR_n(wr_n2),
      .RD_n(rd_n2), .A0(a02), .D_out(d_out2), .D_oe(d_oe2), .D_in(d_in2),
      .INT(int2), .INTA(inta2)
   );

   // Monitor view of whichever instance is selected.
   logic sel;
   wire       m_cs_n      = sel ? cs_n2 : cs_n1;
   wire       m_wr_n      = sel ? wr_n2 : wr_n1;
   wire       m_rd_n      = sel ? rd_n2 : rd_n1;
   wire       m_inta      = sel ? inta2 : inta1;
   wire       m_a0        = sel ? a02 : a01;
   wire       m_d_oe      = sel ? d_oe2 : d_oe1;
   wire [7:0] m_d_out     = sel ? d_out2 : d_out1;
   wire       m_rd_valid  = sel ? rd_valid2 : rd_valid1;
   wire [7:0] m_rd_data   = sel ? rd_data2 : rd_data1;
   wire       m_vec_valid = sel ? vec_valid2 : vec_valid1;
   wire [7:0] m_vec_data  = sel ? vec_data2 : vec_data1;
   wire       m_ready     = sel ? cmd_ready2 : cmd_ready1;
   wire       m_cmd_valid = sel ? cmd_valid2 : cmd_valid1;

   int checks = 0;
   int failures = 0;

   int cyc, cs_low, wr_low, rd_low, a0_bad, oe_bad, dout_bad, ack_bad, both_v;
   int np, rdv_n, vecv_n, rd_cyc, vec_cyc, rd_first, first_ready, drop_mode;
   int p_start[8], p_end[8];
   logic prev_inta, check_bus, exp_a0, exp_oe;
   logic [7:0] exp_dout, rdv_data, vecv_data;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_int(input logic v);
      if (sel) int2 = v;
      else     int1 = v;
   endtask

   task automatic clear_stats();
      cyc = 0; cs_low = 0; wr_low = 0; rd_low = 0; a0_bad = 0; oe_bad = 0;
      dout_bad = 0; ack_bad = 0; both_v = 0; np = 0; rdv_n = 0; vecv_n = 0;
      rd_cyc = -1; vec_cyc = -1; rd_first = -1; first_ready = -1; drop_mode = 0;
      prev_inta = 1'b1; check_bus = 1'b0; rdv_data = 8'h00; vecv_data = 8'h00;
      for (int k = 0; k < 8; k++) begin
         p_start[k] = -1;
         p_end[k]   = -1;
      end
   endtask

   task automatic sample(output logic acc);
      if (!m_cs_n) begin
         cs_low++;
         if (check_bus && m_a0 !== exp_a0) a0_bad++;
         if (check_bus && m_d_oe !== exp_oe) oe_bad++;
         if (check_bus && exp_oe && m_d_out !== exp_dout) dout_bad++;
      end
      if (!m_wr_n) wr_low++;
      if (!m_rd_n) begin
         rd_low++;
         if (rd_first < 0) rd_first = cyc;
      end
      if (!m_inta && (!m_cs_n || m_d_oe)) ack_bad++;
      if (!m_inta && prev_inta) begin
         if (np < 8) p_start[np] = cyc;
         np++;
      end
      if (m_inta && !prev_inta && np > 0 && np <= 8) p_end[np-1] = cyc;
      prev_inta = m_inta;
      if (m_rd_valid) begin rdv_n++; rdv_data = m_rd_data; rd_cyc = cyc; end
      if (m_vec_valid) begin vecv_n++; vecv_data = m_vec_data; vec_cyc = cyc; end
      if (m_rd_valid && m_vec_valid) both_v++;
      if (m_ready && first_ready < 0) first_ready = cyc;
      if (drop_mode == 1 && !m_inta) set_int(1'b0);
      if (drop_mode == 2 && np == 1 && m_inta && p_end[0] >= 0) set_int(1'b0);
      if (drop_mode == 3 && np >= 3) set_int(1'b0);
      acc = m_ready && m_cmd_valid;
      cyc++;
   endtask

   task automatic run(input int n);
      logic acc;
      for (int i = 0; i < n; i++) begin
         sample(acc);
         step();
         if (acc) begin
            if (sel) cmd_valid2 = 1'b0;
            else     cmd_valid1 = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if ({cs_n1, wr_n1, rd_n1, inta1} !== 4'hF) begin failures++; $display("FAIL rst_strobes got=%b exp=1111", {cs_n1, wr_n1, rd_n1, inta1}); end
      checks++; if ({a01, d_oe1} !== 2'b00) begin failures++; $display("FAIL rst_a0_oe got=%b exp=00", {a01, d_oe1}); end
      checks++; if (d_out1 !== 8'h00) begin failures++; $display("FAIL rst_d_out got=%h exp=00", d_out1); end
      checks++; if (cmd_ready1 !== 1'b0) begin failures++; $display("FAIL rst_ready_held got=%b exp=0", cmd_ready1); end
      checks++; if ({rd_data1, vec_data1} !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", {rd_data1, vec_data1}); end
      checks++; if ({rd_valid1, vec_valid1, busy1} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {rd_valid1, vec_valid1, busy1}); end
      checks++; if ({cs_n2, inta2, busy2} !== 3'b110) begin failures++; $display("FAIL rst_dut2 got=%b exp=110", {cs_n2, inta2, busy2}); end
      reset = 1'b0;
      step();
      checks++; if ({cmd_ready1, busy1} !== 2'b10) begin failures++; $display("FAIL rst_release got=%b exp=10", {cmd_ready1, busy1}); end
   endtask

   task automatic test_write();
      sel = 1'b0;
      cmd_valid1 = 1'b1; cmd_read1 = 1'b0; cmd_a01 = 1'b0; cmd_data1 = 8'h13;
      checks++; if (cmd_ready1 !== 1'b1) begin failures++; $display("FAIL wr_ready_idle got=%b exp=1", cmd_ready1); end
      step();
      cmd_valid1 = 1'b0; cmd_data1 = 8'hFF;
      clear_stats();
      check_bus = 1'b1; exp_a0 = 1'b0; exp_oe = 1'b1; exp_dout = 8'h13;
      run(12);
      checks++; if (cs_low !== 4) begin failures++; $display("FAIL wr_cs_low got=%0d exp=4", cs_low); end
      checks++; if (wr_low !== 2) begin failures++; $display("FAIL wr_wr_low got=%0d exp=2", wr_low); end
      checks++; if (rd_low !== 0) begin failures++; $display("FAIL wr_rd_low got=%0d exp=0", rd_low); end
      checks++; if (dout_bad !== 0) begin failures++; $display("FAIL wr_d_out_stable got=%0d bad cycles exp=0", dout_bad); end
      checks++; if (a0_bad + oe_bad !== 0) begin failures++; $display("FAIL wr_a0_oe got=%0d bad cycles exp=0", a0_bad + oe_bad); end
      checks++; if (first_ready !== 6) begin failures++; $display("FAIL wr_ready_return got=%0d exp=6", first_ready); end
   endtask

   task automatic test_read();
      sel = 1'b0;
      pic_reg = 8'hA5;
      cmd_valid1 = 1'b1; cmd_read1 = 1'b1; cmd_a01 = 1'b1; cmd_data1 = 8'h00;
      step();
      cmd_valid1 = 1'b0; cmd_a01 = 1'b0;
      clear_stats();
      check_bus = 1'b1; exp_a0 = 1'b1; exp_oe = 1'b0; exp_dout = 8'h00;
      run(12);
      checks++; if (rd_low !== 2) begin failures++; $display("FAIL rd_rd_low got=%0d exp=2", rd_low); end
      checks++; if (wr_low !== 0) begin failures++; $display("FAIL rd_wr_low got=%0d exp=0", wr_low); end
      checks++; if (rdv_n !== 1) begin failures++; $display("FAIL rd_valid_pulses got=%0d exp=1", rdv_n); end
      checks++; if (rdv_data !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", rdv_data); end
      checks++; if (rd_cyc !== 3) begin failures++; $display("FAIL rd_valid_cycle got=%0d exp=3", rd_cyc); end
      checks++; if (a0_bad + oe_bad !== 0) begin failures++; $display("FAIL rd_a0_oe got=%0d bad cycles exp=0", a0_bad + oe_bad); end
   endtask

   task automatic test_int_priority();
      sel = 1'b0;
      cmd_valid1 = 1'b1; cmd_read1 = 1'b0; cmd_a01 = 1'b0; cmd_data1 = 8'h20;
      step();
      cmd_valid1 = 1'b0;
      clear_stats();
      run(2);
      // INT and a read request arrive together while the write finishes.
      pic_reg = 8'h5A; pic_vec = 8'h48; drop_mode = 1;
      int1 = 1'b1; cmd_valid1 = 1'b1; cmd_read1 = 1'b1; cmd_a01 = 1'b1;
      run(40);
      checks++; if (np !== 2) begin failures++; $display("FAIL pri_pulses got=%0d exp=2", np); end
      checks++; if (p_start[0] !== 7) begin failures++; $display("FAIL pri_ack_start got=%0d exp=7", p_start[0]); end
      checks++; if (p_end[0] - p_start[0] !== 2 || p_end[1] - p_start[1] !== 2) begin failures++; $display("FAIL pri_widths got=%0d,%0d exp=2,2", p_end[0] - p_start[0], p_end[1] - p_start[1]); end
      checks++; if (p_start[1] - p_end[0] !== 2) begin failures++; $display("FAIL pri_gap got=%0d exp=2", p_start[1] - p_end[0]); end
      checks++; if (vecv_n !== 1 || vecv_data !== 8'h48) begin failures++; $display("FAIL pri_vec got=%0d x %h exp=1 x 48", vecv_n, vecv_data); end
      checks++; if (first_ready !== 15) begin failures++; $display("FAIL pri_ready_held got=%0d exp=15", first_ready); end
      checks++; if (rd_first <= vec_cyc) begin failures++; $display("FAIL pri_cmd_after_ack got=%0d exp>%0d", rd_first, vec_cyc); end
      checks++; if (rdv_n !== 1 || rdv_data !== 8'h5A) begin failures++; $display("FAIL pri_read got=%0d x %h exp=1 x 5a", rdv_n, rdv_data); end
      checks++; if (ack_bad + both_v !== 0) begin failures++; $display("FAIL pri_ack_bus got=%0d exp=0", ack_bad + both_v); end
   endtask

   task automatic test_int_drop_gap();
      sel = 1'b0;
      clear_stats();
      pic_vec = 8'h4F; drop_mode = 2;
      int1 = 1'b1;
      run(40);
      checks++; if (np !== 2) begin failures++; $display("FAIL drop_pulses got=%0d exp=2", np); end
      checks++; if (p_end[1] - p_start[1] !== 2) begin failures++; $display("FAIL drop_ack2_width got=%0d exp=2", p_end[1] - p_start[1]); end
      checks++; if (vecv_n !== 1 || vecv_data !== 8'h4F) begin failures++; $display("FAIL drop_vec got=%0d x %h exp=1 x 4f", vecv_n, vecv_data); end
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      clear_stats();
      pic_vec = 8'h41; drop_mode = 3;
      int1 = 1'b1;
      run(40);
      checks++; if (np !== 4) begin failures++; $display("FAIL b2b_pulses got=%0d exp=4", np); end
      checks++; if (p_start[2] - p_end[1] !== 3) begin failures++; $display("FAIL b2b_restart got=%0d exp=3", p_start[2] - p_end[1]); end
      checks++; if (vecv_n !== 2) begin failures++; $display("FAIL b2b_vec_pulses got=%0d exp=2", vecv_n); end
   endtask

   task automatic test_reset_ack2();
      logic acc;
      bit   found;
      sel = 1'b0;
      clear_stats();
      pic_vec = 8'h66;
      int1 = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         sample(acc);
         if (np == 2) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++; if (!found) begin failures++; $display("FAIL rack2_reach got=no ACK2 exp=ACK2 within 30 cycles"); end
      reset = 1'b1; int1 = 1'b0;
      step();
      checks++; if ({inta1, busy1, vec_valid1, cs_n1} !== 4'b1001) begin failures++; $display("FAIL rack2_abort got=%b exp=1001", {inta1, busy1, vec_valid1, cs_n1}); end
      step();
      reset = 1'b0;
      clear_stats();
      run(10);
      checks++; if (vecv_n + np !== 0) begin failures++; $display("FAIL rack2_no_vec got=%0d exp=0", vecv_n + np); end
   endtask

   task automatic test_dut2_timing();
      sel = 1'b1;
      clear_stats();
      pic_vec = 8'h77; drop_mode = 1;
      int2 = 1'b1;
      run(60);
      checks++; if (np !== 2) begin failures++; $display("FAIL t2_pulses got=%0d exp=2", np); end
      checks++; if (p_end[0] - p_start[0] !== 1 || p_end[1] - p_start[1] !== 1) begin failures++; $display("FAIL t2_widths got=%0d,%0d exp=1,1", p_end[0] - p_start[0], p_end[1] - p_start[1]); end
      checks++; if (p_start[1] - p_end[0] !== 15) begin failures++; $display("FAIL t2_gap got=%0d exp=15", p_start[1] - p_end[0]); end
      checks++; if (vecv_data !== 8'h77) begin failures++; $display("FAIL t2_vec got=%h exp=77", vecv_data); end
      cmd_valid2 = 1'b1; cmd_read2 = 1'b0; cmd_a02 = 1'b1; cmd_data2 = 8'h3C;
      checks++; if (cmd_ready2 !== 1'b1) begin failures++; $display("FAIL t2_ready_idle got=%b exp=1", cmd_ready2); end
      step();
      cmd_valid2 = 1'b0;
      clear_stats();
      check_bus = 1'b1; exp_a0 = 1'b1; exp_oe = 1'b1; exp_dout = 8'h3C;
      run(25);
      checks++; if (wr_low !== 1 || cs_low !== 3) begin failures++; $display("FAIL t2_write got=wr%0d cs%0d exp=wr1 cs3", wr_low, cs_low); end
      checks++; if (first_ready !== 18) begin failures++; $display("FAIL t2_recov got=%0d exp=18", first_ready); end
      checks++; if (busy2 !== 1'b0 || dout_bad + a0_bad !== 0) begin failures++; $display("FAIL t2_idle_bus got=busy%b bad%0d exp=busy0 bad0", busy2, dout_bad + a0_bad); end
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; pic_reg = 8'h00; pic_vec = 8'h00;
      cmd_valid1 = 1'b0; cmd_read1 = 1'b0; cmd_a01 = 1'b0; cmd_data1 = 8'h00; int1 = 1'b0;
      cmd_valid2 = 1'b0; cmd_read2 = 1'b0; cmd_a02 = 1'b0; cmd_data2 = 8'h00; int2 = 1'b0;
      clear_stats();
      test_reset();
      test_write();
      test_read();
      test_int_priority();
      test_int_drop_gap();
      test_back_to_back();
      test_reset_ack2();
      test_dut2_timing();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
